// File: rtl/reg_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_master_if
// Description : Command/response stream and register-bus signal bundle for
//               reg_bus_master. The master modport is the initiator's view;
//               the slave modport is the view of whatever sits around it
//               (command source, response sink and register file).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 12
);
  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  // Register file bus
  logic              bus_write_en;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  bus_rdata,
    output cmd_ready,
    output rsp_valid, rsp_data,
    output bus_write_en, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    output bus_rdata,
    input  cmd_ready,
    input  rsp_valid, rsp_data,
    input  bus_write_en, bus_addr, bus_wdata
  );
endinterface
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_master
// Description : Command-driven initiator for the cipher register bus. Takes
//               single read/write commands, drives addr/write_en/data_in of
//               the register file and samples its combinational data_out.
//               A write to the character-input register waits for the cipher
//               path to settle and then returns the character-output value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_master #(
  parameter int                ADDR_W        = 4,
  parameter int                DATA_W        = 12,
  // Legal range 1..15; the settle counter is 4 bits wide.
  parameter int                SETTLE_CYCLES = 2,
  parameter logic [ADDR_W-1:0] CHAR_IN_ADDR  = ADDR_W'(13),
  parameter logic [ADDR_W-1:0] CHAR_OUT_ADDR = ADDR_W'(14)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  reg_bus_master_if.master   bus,
  output logic               busy
);

  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_SETTLE = 3'd2,
    S_READ   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic [3:0]        r_count;

  // Single state machine; every output is a register updated together with
  // the state so that outputs always describe the current state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_write_en  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_wdata;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.cmd_write) begin
              // Write strobe is raised for exactly the WRITE cycle.
              r_write_en <= 1'b1;
              r_state    <= S_WRITE;
            end else begin
              r_state    <= S_READ;
            end
          end
        end

        S_WRITE: begin
          r_write_en <= 1'b0;
          if (r_addr == CHAR_IN_ADDR) begin
            r_count <= C_SETTLE_LOAD;
            r_state <= S_SETTLE;
          end else begin
            // Plain writes complete silently.
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_SETTLE: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            // Point the bus at the cipher output for the upcoming READ.
            r_addr  <= CHAR_OUT_ADDR;
            r_state <= S_READ;
          end
        end

        S_READ: begin
          // data_out is combinational, so it is valid within this cycle.
          r_rsp_data  <= bus.bus_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_write_en  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.bus_write_en = r_write_en;
  assign bus.bus_addr     = r_addr;
  assign bus.bus_wdata    = r_wdata;
  assign busy             = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_master
// Description : Self-checking bench for reg_bus_master with a behavioural
//               register file (reg 11 resets to 1, reg 15 reads 0, reg 14 is
//               a one-cycle-late cipher of reg 13: out = in + 12'h00B).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   cyc   = 0;

  reg_bus_master_if #(.ADDR_W(4), .DATA_W(12)) bif ();

  reg_bus_master #(
    .ADDR_W        (4),
    .DATA_W        (12),
    .SETTLE_CYCLES (2),
    .CHAR_IN_ADDR  (4'd13),
    .CHAR_OUT_ADDR (4'd14)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .busy  (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Cycle index: value after edge N is N
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file
  logic [11:0] regs [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 12'd0;
      regs[11] <= 12'd1;
    end else begin
      if (bif.bus_write_en && bif.bus_addr != 4'd15) regs[bif.bus_addr] <= bif.bus_wdata;
      regs[14] <= regs[13] + 12'h00B;
    end
  end
  assign bif.bus_rdata = (bif.bus_addr == 4'd15) ? 12'd0 : regs[bif.bus_addr];

  // Scoreboard state
  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] exp_q [$];
  logic        prev_we     = 1'b0;
  int          we_pulses   = 0;
  int          acc_cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops expected responses on every response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.bus_write_en) check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (bif.bus_write_en && !prev_we) we_pulses <= we_pulses + 1;
      if (bif.rsp_valid && bif.rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got %0h expected no response", bif.rsp_data);
        end else begin
          check("rsp_data", {20'd0, bif.rsp_data}, {20'd0, exp_q.pop_front()});
        end
      end
    end
    prev_we <= bif.bus_write_en;
  end

  // Wait for cmd_ready, let the handshake edge pass, drop cmd_valid.
  task automatic wait_accept();
    int n = 0;
    logic got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bif.cmd_ready) got = 1'b1;
      else n++;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [11:0] d);
    bif.cmd_write = w;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
    bif.cmd_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses_before;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 4'd0;
    bif.cmd_wdata = 12'd0;
    bif.rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    check("rst_rsp_data",  {20'd0, bif.rsp_data}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);
    check("idle_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    check("idle_we",        {31'd0, bif.bus_write_en}, 32'd0);
    check("idle_addr",      {28'd0, bif.bus_addr}, 32'd0);
    check("idle_wdata",     {20'd0, bif.bus_wdata}, 32'd0);
    check("idle_busy",      {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Read addr 10 straight after reset, with latency checks
    exp_q.push_back(12'd0);
    issue(1'b0, 4'd10, 12'hFFF);
    @(negedge clk);
    check("rd_addr",      {28'd0, bif.bus_addr}, 32'd10);
    check("rd_we",        {31'd0, bif.bus_write_en}, 32'd0);
    check("rd_valid_N",   {31'd0, bif.rsp_valid}, 32'd0);
    check("rd_busy",      {31'd0, busy}, 32'd0 + 32'd1);
    check("rd_ready_N",   {31'd0, bif.cmd_ready}, 32'd0);
    @(negedge clk);
    check("rd_valid_N1",  {31'd0, bif.rsp_valid}, 32'd1);
    @(negedge clk);
    check("rd_idle_N2",   {31'd0, bif.cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Read addr 11 (reset value 1)
    exp_q.push_back(12'd1);
    issue(1'b0, 4'd11, 12'd0);

    // Plain write addr 3 then read back
    issue(1'b1, 4'd3, 12'h011);
    @(negedge clk);
    check("wr_we",        {31'd0, bif.bus_write_en}, 32'd1);
    check("wr_addr",      {28'd0, bif.bus_addr}, 32'd3);
    check("wr_wdata",     {20'd0, bif.bus_wdata}, 32'h011);
    @(negedge clk);
    check("wr_we_off",    {31'd0, bif.bus_write_en}, 32'd0);
    check("wr_ready_N1",  {31'd0, bif.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(12'h011);
    issue(1'b0, 4'd3, 12'd0);

    // Full-width data and address 15 pass-through
    issue(1'b1, 4'd5, 12'hFFF);
    exp_q.push_back(12'hFFF);
    issue(1'b0, 4'd5, 12'd0);
    issue(1'b1, 4'd15, 12'hABC);
    @(negedge clk);
    check("a15_addr",     {28'd0, bif.bus_addr}, 32'd15);
    check("a15_wdata",    {20'd0, bif.bus_wdata}, 32'hABC);
    @(posedge clk); #1;
    exp_q.push_back(12'd0);
    issue(1'b0, 4'd15, 12'd0);

    // Char-input write: response at accept+4
    exp_q.push_back(12'h012);
    issue(1'b1, 4'd13, 12'h007);
    @(negedge clk);
    check("ch_we",        {31'd0, bif.bus_write_en}, 32'd1);
    check("ch_addr_w",    {28'd0, bif.bus_addr}, 32'd13);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ch_settle_we",    {31'd0, bif.bus_write_en}, 32'd0);
      check("ch_settle_busy",  {31'd0, busy}, 32'd1);
      check("ch_settle_valid", {31'd0, bif.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check("ch_read_addr",  {28'd0, bif.bus_addr}, 32'd14);
    check("ch_read_valid", {31'd0, bif.rsp_valid}, 32'd0);
    @(negedge clk);
    check("ch_rsp_valid",  {31'd0, bif.rsp_valid}, 32'd1);
    check("ch_rsp_cycle",  32'(cyc - acc_cyc), 32'd4);
    @(posedge clk); #1;

    // Response back-pressure with a second command waiting
    bif.rsp_ready = 1'b0;
    exp_q.push_back(12'h011);
    issue(1'b0, 4'd3, 12'd0);
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 4'd11;
    bif.cmd_valid = 1'b1;
    exp_q.push_back(12'd1);
    @(negedge clk);
    check("bp_ready_read", {31'd0, bif.cmd_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bif.rsp_valid}, 32'd1);
      check("bp_data",  {20'd0, bif.rsp_data}, 32'h011);
      check("bp_ready", {31'd0, bif.cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_take_ready", {31'd0, bif.cmd_ready}, 32'd0);
    wait_accept();
    check("bp_accept_cycle", 32'(acc_cyc), 32'(cyc));
    @(negedge clk);
    check("bp_second_addr", {28'd0, bif.bus_addr}, 32'd11);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Reset during SETTLE
    issue(1'b1, 4'd13, 12'h005);
    @(negedge clk);
    check("rs_we", {31'd0, bif.bus_write_en}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    pulses_before = we_pulses;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rs_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);
    check("rs_busy",      {31'd0, busy}, 32'd0);
    check("rs_we_off",    {31'd0, bif.bus_write_en}, 32'd0);
    check("rs_rsp_valid", {31'd0, bif.rsp_valid}, 32'd0);
    repeat (8) @(negedge clk);
    check("rs_no_rsp",    {31'd0, bif.rsp_valid}, 32'd0);
    check("rs_no_pulse",  32'(we_pulses), 32'(pulses_before));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
